ext_onehot_decoder: RTL and testbench

- Receive-side counterpart of the extender's one-hot output stream.
- Accepts EXTENDER_OUT_PART_COUNT-base one-hot parts and decodes each base back to its BASE_LEN-bit code.
- Reassembles KMER_LEN-base kmers, tags each with a sequence number within the current fragment, and flags encoding errors.
- Sits between the extender output and downstream kmer consumers (kmer buffer / hasher path).

---
 rtl/ext_onehot_decoder_pkg.sv | 46 ++++
 rtl/ext_onehot_decoder_base.sv | 24 ++
 rtl/ext_onehot_decoder.sv | 172 +++++++++++++++++
 tb/tb_ext_onehot_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_onehot_decoder_pkg.sv
// Shared types and constants for the one-hot kmer decoder.
// Optional feature macro: ERR_COUNTER_EN (adds err_count output).
package ext_onehot_decoder_pkg;

    localparam int BASE_LEN    = 2;
    localparam int ONE_HOT_LEN = 4;

    localparam int EXTENDER_OUT_PART_COUNT       = 2;
    localparam int KMER_LEN                      = 4;
    localparam int SORTER_EXTENDER_INDICES_COUNT = 4;

    localparam int PART_COUNT = EXTENDER_OUT_PART_COUNT;
    localparam int KMER_BASES = KMER_LEN;
    localparam int SEQ_COUNT  = SORTER_EXTENDER_INDICES_COUNT;

    localparam int PARTS_PER_KMER = KMER_BASES / PART_COUNT;

    localparam int PART_W    = PART_COUNT * ONE_HOT_LEN;
    localparam int PART_BITS = PART_COUNT * BASE_LEN;
    localparam int KMER_W    = KMER_BASES * BASE_LEN;
    localparam int SEQ_W     = $clog2(SEQ_COUNT);
    localparam int CNT_W     =
        (PARTS_PER_KMER > 1) ? $clog2(PARTS_PER_KMER) : 1;

    typedef logic [BASE_LEN-1:0]    base_t;
    typedef logic [KMER_W-1:0]      kmer_t;
    typedef logic [ONE_HOT_LEN-1:0] onehot_t;

    localparam onehot_t OH_A = 4'b0001;
    localparam onehot_t OH_C = 4'b0010;
    localparam onehot_t OH_G = 4'b0100;
    localparam onehot_t OH_T = 4'b1000;

    // Number of set bits in a per-slot invalid vector.
    function automatic logic [1:0] count_bad(
        input logic [PART_COUNT-1:0] v
    );
        logic [1:0] n;
        n = '0;
        for (int i = 0; i < PART_COUNT; i++) begin
            n = n + {1'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ext_onehot_decoder_base.sv
// Combinational decode of one one-hot slot to a 2-bit base.
// Zero or multi-hot codes map to A and raise invalid_o.
module onehot_base_decoder
    import ext_onehot_decoder_pkg::*;
(
    input  onehot_t slot_i,
    output base_t   base_o,
    output logic    invalid_o
);

    // Map each legal code to its base; anything else is an error.
    always_comb begin
        base_o    = '0;
        invalid_o = 1'b0;
        case (slot_i)
            OH_A:    base_o = 2'b00;
            OH_C:    base_o = 2'b01;
            OH_G:    base_o = 2'b10;
            OH_T:    base_o = 2'b11;
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ext_onehot_decoder.sv
// Reassembles one-hot parts into kmers with seq tags and error flags.
// Optional feature macro: ERR_COUNTER_EN (adds err_count output).
module ext_onehot_decoder
    import ext_onehot_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PART_W-1:0] in_part,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output kmer_t             out_kmer,
    output logic [SEQ_W-1:0]  out_seq,
    output logic              out_err,
    output logic              out_last,
    output logic              frag_done
`ifdef ERR_COUNTER_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PARTS_PER_KMER - 1);
    localparam logic [SEQ_W-1:0] SEQ_MAX  = SEQ_W'(SEQ_COUNT - 1);

    base_t                 dec_base [PART_COUNT];
    logic [PART_COUNT-1:0] dec_bad;
    logic [PART_BITS-1:0]  part_bits;

    logic [CNT_W-1:0] part_cnt_q, part_cnt_d;
    kmer_t            acc_q, acc_d;
    logic             acc_err_q, acc_err_d;

    logic             out_valid_q, out_valid_d;
    kmer_t            out_kmer_q, out_kmer_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             out_err_q, out_err_d;
    logic             out_last_q, out_last_d;
    logic             frag_done_q, frag_done_d;

    logic  completes, acc_fire, out_fire, emit, truncated;
    kmer_t acc_shift, emit_kmer;

    for (genvar g = 0; g < PART_COUNT; g++) begin : g_dec
        onehot_base_decoder u_dec (
            .slot_i    (in_part[g*ONE_HOT_LEN +: ONE_HOT_LEN]),
            .base_o    (dec_base[g]),
            .invalid_o (dec_bad[g])
        );
    end

    // Slot 0 is the earlier base, so it lands in the upper bits.
    always_comb begin
        part_bits = '0;
        for (int i = 0; i < PART_COUNT; i++) begin
            part_bits[PART_BITS-1-i*BASE_LEN -: BASE_LEN] = dec_base[i];
        end
    end

    assign completes = (part_cnt_q == LAST_CNT) || in_last;
    assign in_ready  = !(out_valid_q && !out_ready && in_valid && completes);
    assign acc_fire  = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign emit      = acc_fire && completes;
    assign truncated = (part_cnt_q != LAST_CNT);

    // Short kmers are left-aligned so missing bases pad as A.
    assign acc_shift = (acc_q << PART_BITS) | kmer_t'(part_bits);
    assign emit_kmer =
        acc_shift << (PART_BITS * int'(LAST_CNT - part_cnt_q));

    // Accumulator: gather parts, clear when a kmer is handed off.
    always_comb begin
        part_cnt_d = part_cnt_q;
        acc_d      = acc_q;
        acc_err_d  = acc_err_q;
        if (emit) begin
            part_cnt_d = '0;
            acc_d      = '0;
            acc_err_d  = 1'b0;
        end else if (acc_fire) begin
            part_cnt_d = part_cnt_q + CNT_W'(1);
            acc_d      = acc_shift;
            acc_err_d  = acc_err_q | (|dec_bad);
        end
    end

    // Output register: reload on emit, drop valid on a bare handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        out_kmer_d  = out_kmer_q;
        out_err_d   = out_err_q;
        out_last_d  = out_last_q;
        seq_d       = seq_q;
        frag_done_d = out_fire && out_last_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
            if (out_last_q || seq_q == SEQ_MAX) begin
                seq_d = '0;
            end else begin
                seq_d = seq_q + SEQ_W'(1);
            end
        end
        if (emit) begin
            out_valid_d = 1'b1;
            out_kmer_d  = emit_kmer;
            out_err_d   = acc_err_q | (|dec_bad) | truncated;
            out_last_d  = in_last;
        end
    end

    // State registers for accumulator, output and fragment pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            part_cnt_q  <= '0;
            acc_q       <= '0;
            acc_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_kmer_q  <= '0;
            out_err_q   <= 1'b0;
            out_last_q  <= 1'b0;
            seq_q       <= '0;
            frag_done_q <= 1'b0;
        end else begin
            part_cnt_q  <= part_cnt_d;
            acc_q       <= acc_d;
            acc_err_q   <= acc_err_d;
            out_valid_q <= out_valid_d;
            out_kmer_q  <= out_kmer_d;
            out_err_q   <= out_err_d;
            out_last_q  <= out_last_d;
            seq_q       <= seq_d;
            frag_done_q <= frag_done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_kmer  = out_kmer_q;
    assign out_seq   = seq_q;
    assign out_err   = out_err_q;
    assign out_last  = out_last_q;
    assign frag_done = frag_done_q;

`ifdef ERR_COUNTER_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [8:0] err_sum;

    assign err_sum = {1'b0, err_cnt_q} + 9'(count_bad(dec_bad));

    // Count invalid one-hot codes on accepted parts, saturating.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (acc_fire) begin
            err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ext_onehot_decoder.sv
// Self-checking bench for ext_onehot_decoder: directed + random traffic.
// Compares DUT against a base-list reference model every cycle.
module tb_ext_onehot_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_part;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_kmer;
    logic [1:0] out_seq;
    logic       out_err;
    logic       out_last;
    logic       frag_done;
`ifdef ERR_COUNTER_EN
    logic [7:0] err_count;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    ext_onehot_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_part   (in_part),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kmer  (out_kmer),
        .out_seq   (out_seq),
        .out_err   (out_err),
        .out_last  (out_last),
        .frag_done (frag_done)
`ifdef ERR_COUNTER_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] kmer;
        int         seq;
        bit         err;
        bit         last;
    } exp_t;

    exp_t q[$];
    int   bufb[$];
    bit   berr;
    int   frag_idx;
    bit   fd_exp;
    int   ecnt;

    function automatic int dec(input logic [3:0] c, output bit bad);
        for (int k = 0; k < 4; k++) begin
            if (c == (4'b0001 << k)) begin
                bad = 1'b0;
                return k;
            end
        end
        bad = 1'b1;
        return 0;
    endfunction

    // Compare DUT to model on every falling edge, then advance model.
    always @(negedge clk) begin
        bit   exp_v, exp_rdy, bad;
        int   b;
        exp_t e;
        if (rst) begin
            check("reset_outs",
                  {out_valid, out_kmer, out_seq, out_err, out_last,
                   frag_done}, 0);
`ifdef ERR_COUNTER_EN
            check("reset_errcnt", err_count, 0);
`endif
            q.delete();
            bufb.delete();
            berr = 0;
            frag_idx = 0;
            fd_exp = 0;
            ecnt = 0;
        end else begin
            exp_v = (q.size() > 0);
            check("out_valid", out_valid, exp_v);
            if (out_valid && exp_v) begin
                check("out_kmer", out_kmer, q[0].kmer);
                check("out_seq", out_seq, q[0].seq);
                check("out_err", out_err, q[0].err);
                check("out_last", out_last, q[0].last);
            end
            check("frag_done", frag_done, fd_exp);
            exp_rdy = !(exp_v && !out_ready && in_valid &&
                        ((bufb.size() / 2) == 1 || in_last));
            check("in_ready", in_ready, exp_rdy);
`ifdef ERR_COUNTER_EN
            check("err_count", err_count, ecnt);
`endif
            fd_exp = 0;
            if (exp_v && out_ready) begin
                fd_exp = q[0].last;
                void'(q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                for (int s = 0; s < 2; s++) begin
                    b = dec(in_part[4*s +: 4], bad);
                    bufb.push_back(b);
                    if (bad) begin
                        berr = 1;
                        if (ecnt < 255) ecnt++;
                    end
                end
                if (bufb.size() == 4 || in_last) begin
                    e.err = berr || (bufb.size() < 4);
                    while (bufb.size() < 4) bufb.push_back(0);
                    e.kmer = 0;
                    foreach (bufb[i]) e.kmer = (e.kmer << 2) | 8'(bufb[i]);
                    e.seq = frag_idx % 4;
                    e.last = in_last;
                    q.push_back(e);
                    frag_idx = in_last ? 0 : frag_idx + 1;
                    bufb.delete();
                    berr = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_part(input logic [7:0] p, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_part  = p;
        in_last  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [3:0] rand_slot();
        logic [3:0] v;
        if ($urandom_range(0, 99) < 85) v = 4'b0001 << $urandom_range(0, 3);
        else v = 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_part = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("lit_reset_ready", in_ready, 1);
        tick();

        // Plain full kmer closing a fragment.
        send_part(8'b0010_0001, 0);
        send_part(8'b1000_0100, 1);
        check("lit_1b_kmer", out_kmer, 8'h1B);
        check("lit_1b_seq", out_seq, 0);
        check("lit_1b_err", out_err, 0);
        check("lit_1b_last", out_last, 1);
        tick();
        check("lit_fd_pulse", frag_done, 1);
        tick();
        check("lit_fd_low", frag_done, 0);

        // Multi-hot slot decodes to A and flags error.
        send_part(8'b0001_0011, 0);
        send_part(8'b0001_0001, 1);
        check("lit_bad_kmer", out_kmer, 8'h00);
        check("lit_bad_err", out_err, 1);
`ifdef ERR_COUNTER_EN
        check("lit_errcnt", err_count, 1);
`endif
        tick();
        tick();

        // Backpressure: stall only on the completing part.
        out_ready = 1'b0;
        send_part(8'b0010_0001, 0);
        send_part(8'b1000_0100, 0);
        check("lit_bp_k1", out_kmer, 8'h1B);
        send_part(8'b0100_0010, 0);
        in_valid = 1'b1;
        in_part = 8'b0001_1000;
        in_last = 1'b0;
        @(negedge clk);
        check("lit_bp_stall", in_ready, 0);
        check("lit_bp_hold", out_kmer, 8'h1B);
        tick();
        @(negedge clk);
        check("lit_bp_stall2", in_ready, 0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("lit_bp_release", in_ready, 1);
        check("lit_bp_seq0", out_seq, 0);
        tick();
        in_valid = 1'b0;
        check("lit_bp_k2v", out_valid, 1);
        check("lit_bp_k2", out_kmer, 8'h6C);
        check("lit_bp_seq1", out_seq, 1);
        tick();

        // Reset mid-accumulation discards the partial kmer.
        send_part(8'b0001_0001, 0);
        rst = 1'b1;
        @(negedge clk);
        check("lit_rst_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        check("lit_rst_ready", in_ready, 1);
        check("lit_rst_seq", out_seq, 0);
        send_part(8'b0010_0001, 0);
        send_part(8'b1000_0100, 0);
        check("lit_rst_kmer", out_kmer, 8'h1B);
        check("lit_rst_kseq", out_seq, 0);
        tick();

        // Truncated fragment: one part then last.
        send_part(8'b0100_1000, 1);
        check("lit_tr_kmer", out_kmer, 8'b11_10_00_00);
        check("lit_tr_err", out_err, 1);
        check("lit_tr_last", out_last, 1);
        check("lit_tr_seq", out_seq, 1);
        tick();
        check("lit_tr_seq0", out_seq, 0);

        // Sequence wrap over five kmers.
        for (int k = 0; k < 5; k++) begin
            send_part(8'b0001_0010, 0);
            send_part(8'b0100_1000, 0);
            check("lit_wrap_seq", out_seq, k % 4);
        end
        send_part(8'b0001_0001, 1);
        tick();
        tick();

        // Random traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_part   = {rand_slot(), rand_slot()};
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
